gemm_tile_ctrl: RTL and testbench
=================================

GEMM_TILE_CTRL -- requirements
Module: gemm_tile_ctrl

Interface
REQ-001 Parameter PE_ROWS, default 4: PE array rows, the M-tile height.
REQ-002 Parameter PE_COLS, default 4: PE array columns, the N-tile width.
REQ-003 Parameters MAX_M_SIZE_LOG2 / MAX_K_SIZE_LOG2 / MAX_N_SIZE_LOG2, default 9 each: matrix dimension widths.
REQ-004 Parameters OPND_AWIDTH and OUT_AWIDTH, default 10 each: SRAM address widths.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 RSTn  in  1  synchronous, active-low reset.
REQ-007 START  in  1  level request; accepted only in IDLE.
REQ-008 STALL  in  1  freezes all sequencing while high.
REQ-009 M_SIZE_in, K_SIZE_in, N_SIZE_in  in  MAX_*_SIZE_LOG2 each  matrix dimensions; sampled when START is accepted.
REQ-010 BUSY_out  out  1  high in every non-IDLE state.
REQ-011 IS_FINISHED_out  out  1  one-cycle completion pulse.
REQ-012 OPND1_RD_EN / OPND1_ADDR  out  1 / OPND_AWIDTH  A-operand SRAM read.
REQ-013 OPND2_RD_EN / OPND2_ADDR  out  1 / OPND_AWIDTH  B-operand SRAM read.
REQ-014 ACC_CLR_out  out  1  clears PE accumulators in the first FEED cycle of each tile.
REQ-015 OUT_WR_EN / OUT_ADDR  out  1 / OUT_AWIDTH  result SRAM write.
REQ-016 CYCLE_CNT_out  out  32  busy-cycle count (see Configuration).

Function
REQ-017 States: IDLE, FEED, DRAIN, WRITE, DONE.
REQ-018 Derived counts: MT = ceil(M/PE_ROWS), NT = ceil(N/PE_COLS); tiles are walked with mt outer and nt inner.
REQ-019 Transitions:
- IDLE -> FEED on START.
- FEED lasts K cycles, then -> DRAIN.
- DRAIN lasts PE_ROWS+PE_COLS-1 cycles, then -> WRITE.
- WRITE lasts PE_ROWS cycles, then -> FEED for the next tile, or -> DONE after the last tile.
- DONE lasts one cycle, then -> IDLE.
REQ-020 FEED cycle k: OPND1_ADDR = mt*K+k, OPND2_ADDR = nt*K+k, both RD_EN high.
REQ-021 WRITE cycle r: OUT_ADDR = (mt*PE_ROWS+r)*NT+nt; OUT_WR_EN is high only if mt*PE_ROWS+r < M, so padded rows are not written.
REQ-022 All enables are low outside their state.
REQ-023 Latency: IS_FINISHED_out is high exactly 1 + MT*NT*(K+2*PE_ROWS+PE_COLS-1) unstalled cycles after the START-accept edge.
REQ-024 STALL high: state, counters and addresses hold, and all enables and ACC_CLR_out are low. Resuming continues exactly where the sequence stopped. A STALL in DONE delays the pulse.
REQ-025 START while BUSY_out is high is ignored. Size inputs are not re-sampled mid-operation.
REQ-026 If M, K or N is zero at accept: IDLE -> DONE directly, with no reads or writes; the pulse comes on the next cycle.
REQ-027 START held high through DONE causes a new accept in the following IDLE cycle.
REQ-028 Address arithmetic is computed at full product width and truncated to the address width; wrap-around is the caller's responsibility.

Reset
REQ-029 RSTn low at a rising edge forces IDLE, clears all counters and drives every output to 0, including mid-operation; no completion pulse is produced.

Configuration
REQ-030 Macro GEMM_TILE_CTRL_PERF_CNT_EN defined:
- CYCLE_CNT_out clears on START accept.
- It then increments every cycle BUSY_out is high, including stalled cycles.
- It holds its value in IDLE.
REQ-031 Macro GEMM_TILE_CTRL_PERF_CNT_EN undefined: CYCLE_CNT_out is tied to 0 and no counter logic is synthesised.

Structure
REQ-032 Package gemm_pkg holds the state enum and the default parameter constants.
REQ-033 Sub-module gemm_addr_gen holds the mt/nt/k/r counters and address arithmetic; the FSM remains in gemm_tile_ctrl.

Verification
REQ-034 4x4 array, M=K=N=16, no stall -> 16 tiles; IS_FINISHED_out 433 cycles after accept; CYCLE_CNT_out=433; 256 reads per port; 64 writes.
REQ-035 M=5, K=3, N=4 -> MT=2, NT=1; pulse at 29 cycles; OUT_WR_EN rows 0..4 only; OUT_ADDR 0..4.
REQ-036 M=16, K=0, N=16 -> no RD_EN or WR_EN; IS_FINISHED_out 1 cycle after accept.
REQ-037 M=K=N=16 with STALL high for 10 cycles mid-FEED -> address sequence identical to REQ-034; pulse at 443; CYCLE_CNT_out=443.
REQ-038 RSTn low during WRITE of tile 3 -> next cycle all outputs 0, state IDLE; a new START runs a full 433-cycle sequence.
REQ-039 START pulsed again during FEED -> ignored; exactly one completion pulse.

Source files
------------

// File: rtl/gemm_pkg.sv
// ----------------------------------------------------------------
// gemm_pkg : shared state encoding and default sizes for the GEMM
//            tile controller.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package gemm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int C_PE_ROWS        = 4;
  localparam int C_PE_COLS        = 4;
  localparam int C_SIZE_LOG2      = 9;
  localparam int C_OPND_AWIDTH    = 10;
  localparam int C_OUT_AWIDTH     = 10;

endpackage

`default_nettype wire

// File: rtl/gemm_addr_gen.sv
// ----------------------------------------------------------------
// gemm_addr_gen : tile/k/row counters and SRAM address arithmetic
//                 for the GEMM tile controller.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module gemm_addr_gen
  import gemm_pkg::*;
#(
  parameter int PE_ROWS         = C_PE_ROWS,
  parameter int PE_COLS         = C_PE_COLS,
  parameter int MAX_M_SIZE_LOG2 = C_SIZE_LOG2,
  parameter int MAX_K_SIZE_LOG2 = C_SIZE_LOG2,
  parameter int MAX_N_SIZE_LOG2 = C_SIZE_LOG2,
  parameter int OPND_AWIDTH     = C_OPND_AWIDTH,
  parameter int OUT_AWIDTH      = C_OUT_AWIDTH
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       load,
  input  logic                       run,
  input  state_t                     state,
  input  logic [MAX_M_SIZE_LOG2-1:0] m_size,
  input  logic [MAX_K_SIZE_LOG2-1:0] k_size,
  input  logic [MAX_N_SIZE_LOG2-1:0] n_size,
  output logic [OPND_AWIDTH-1:0]     opnd1_addr,
  output logic [OPND_AWIDTH-1:0]     opnd2_addr,
  output logic [OUT_AWIDTH-1:0]      out_addr,
  output logic                       row_valid,
  output logic                       first_k,
  output logic                       last_k,
  output logic                       last_d,
  output logic                       last_r,
  output logic                       last_tile
);

  localparam int WIDE = MAX_M_SIZE_LOG2 + MAX_K_SIZE_LOG2 + MAX_N_SIZE_LOG2 + 8;
  localparam int RW   = $clog2(PE_ROWS + 1);
  localparam int DW   = $clog2(PE_ROWS + PE_COLS);

  logic [MAX_M_SIZE_LOG2-1:0] r_m_size, r_mt, r_mt_tiles;
  logic [MAX_K_SIZE_LOG2-1:0] r_k_size, r_k;
  logic [MAX_N_SIZE_LOG2-1:0] r_nt, r_nt_tiles;
  logic [RW-1:0]              r_r;
  logic [DW-1:0]              r_d;

  logic            w_last_mt;
  logic            w_last_nt;
  logic [WIDE-1:0] w_row;

  assign w_last_mt = (r_mt == r_mt_tiles - MAX_M_SIZE_LOG2'(1));
  assign w_last_nt = (r_nt == r_nt_tiles - MAX_N_SIZE_LOG2'(1));
  assign first_k   = (r_k == '0);
  assign last_k    = (r_k == r_k_size - MAX_K_SIZE_LOG2'(1));
  assign last_d    = (r_d == DW'(PE_ROWS + PE_COLS - 2));
  assign last_r    = (r_r == RW'(PE_ROWS - 1));
  assign last_tile = w_last_mt && w_last_nt;

  // Wide intermediate arithmetic, truncated only at the address ports
  assign w_row      = WIDE'(r_mt) * WIDE'(PE_ROWS) + WIDE'(r_r);
  assign row_valid  = (w_row < WIDE'(r_m_size));
  assign opnd1_addr = OPND_AWIDTH'(WIDE'(r_mt) * WIDE'(r_k_size) + WIDE'(r_k));
  assign opnd2_addr = OPND_AWIDTH'(WIDE'(r_nt) * WIDE'(r_k_size) + WIDE'(r_k));
  assign out_addr   = OUT_AWIDTH'(w_row * WIDE'(r_nt_tiles) + WIDE'(r_nt));

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_m_size   <= '0;
      r_k_size   <= '0;
      r_mt_tiles <= '0;
      r_nt_tiles <= '0;
      r_mt       <= '0;
      r_nt       <= '0;
      r_k        <= '0;
      r_r        <= '0;
      r_d        <= '0;
    end else if (load) begin
      r_m_size   <= m_size;
      r_k_size   <= k_size;
      r_mt_tiles <= MAX_M_SIZE_LOG2'((WIDE'(m_size) + WIDE'(PE_ROWS - 1)) / WIDE'(PE_ROWS));
      r_nt_tiles <= MAX_N_SIZE_LOG2'((WIDE'(n_size) + WIDE'(PE_COLS - 1)) / WIDE'(PE_COLS));
      r_mt       <= '0;
      r_nt       <= '0;
      r_k        <= '0;
      r_r        <= '0;
      r_d        <= '0;
    end else if (run) begin
      case (state)
        S_FEED:  r_k <= last_k ? '0 : r_k + 1'b1;
        S_DRAIN: r_d <= last_d ? '0 : r_d + 1'b1;
        S_WRITE: begin
          if (last_r) begin
            r_r <= '0;
            if (w_last_nt) begin
              r_nt <= '0;
              r_mt <= w_last_mt ? '0 : r_mt + 1'b1;
            end else begin
              r_nt <= r_nt + 1'b1;
            end
          end else begin
            r_r <= r_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/gemm_tile_ctrl.sv
// ----------------------------------------------------------------
// gemm_tile_ctrl : FEED/DRAIN/WRITE tile sequencer for a systolic
//                  GEMM array. Option macro GEMM_TILE_CTRL_PERF_CNT_EN
//                  enables the busy-cycle counter on CYCLE_CNT_out.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module gemm_tile_ctrl
  import gemm_pkg::*;
#(
  parameter int PE_ROWS         = C_PE_ROWS,
  parameter int PE_COLS         = C_PE_COLS,
  parameter int MAX_M_SIZE_LOG2 = C_SIZE_LOG2,
  parameter int MAX_K_SIZE_LOG2 = C_SIZE_LOG2,
  parameter int MAX_N_SIZE_LOG2 = C_SIZE_LOG2,
  parameter int OPND_AWIDTH     = C_OPND_AWIDTH,
  parameter int OUT_AWIDTH      = C_OUT_AWIDTH
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       START,
  input  logic                       STALL,
  input  logic [MAX_M_SIZE_LOG2-1:0] M_SIZE_in,
  input  logic [MAX_K_SIZE_LOG2-1:0] K_SIZE_in,
  input  logic [MAX_N_SIZE_LOG2-1:0] N_SIZE_in,
  output logic                       BUSY_out,
  output logic                       IS_FINISHED_out,
  output logic                       OPND1_RD_EN,
  output logic [OPND_AWIDTH-1:0]     OPND1_ADDR,
  output logic                       OPND2_RD_EN,
  output logic [OPND_AWIDTH-1:0]     OPND2_ADDR,
  output logic                       ACC_CLR_out,
  output logic                       OUT_WR_EN,
  output logic [OUT_AWIDTH-1:0]      OUT_ADDR,
  output logic [31:0]                CYCLE_CNT_out
);

  state_t r_state, w_next;
  logic   r_finished;
  logic   w_run, w_accept, w_zero;
  logic   w_row_valid, w_first_k, w_last_k, w_last_d, w_last_r, w_last_tile;

  assign w_run    = !STALL;
  assign w_accept = (r_state == S_IDLE) && START && w_run;
  assign w_zero   = (M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0);

  gemm_addr_gen #(
    .PE_ROWS         (PE_ROWS),
    .PE_COLS         (PE_COLS),
    .MAX_M_SIZE_LOG2 (MAX_M_SIZE_LOG2),
    .MAX_K_SIZE_LOG2 (MAX_K_SIZE_LOG2),
    .MAX_N_SIZE_LOG2 (MAX_N_SIZE_LOG2),
    .OPND_AWIDTH     (OPND_AWIDTH),
    .OUT_AWIDTH      (OUT_AWIDTH)
  ) u_addr_gen (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .load       (w_accept),
    .run        (w_run),
    .state      (r_state),
    .m_size     (M_SIZE_in),
    .k_size     (K_SIZE_in),
    .n_size     (N_SIZE_in),
    .opnd1_addr (OPND1_ADDR),
    .opnd2_addr (OPND2_ADDR),
    .out_addr   (OUT_ADDR),
    .row_valid  (w_row_valid),
    .first_k    (w_first_k),
    .last_k     (w_last_k),
    .last_d     (w_last_d),
    .last_r     (w_last_r),
    .last_tile  (w_last_tile)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_finished <= (r_state == S_DONE) && w_run;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_run) begin
      unique case (r_state)
        S_IDLE:  if (START) w_next = w_zero ? S_DONE : S_FEED;
        S_FEED:  if (w_last_k) w_next = S_DRAIN;
        S_DRAIN: if (w_last_d) w_next = S_WRITE;
        S_WRITE: if (w_last_r) w_next = w_last_tile ? S_DONE : S_FEED;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign BUSY_out        = (r_state != S_IDLE);
  assign IS_FINISHED_out = r_finished;
  assign OPND1_RD_EN     = (r_state == S_FEED) && w_run;
  assign OPND2_RD_EN     = (r_state == S_FEED) && w_run;
  assign ACC_CLR_out     = (r_state == S_FEED) && w_run && w_first_k;
  assign OUT_WR_EN       = (r_state == S_WRITE) && w_run && w_row_valid;

`ifdef GEMM_TILE_CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;

  // Stalled cycles count too: the counter measures wall time while busy
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_cycle_cnt <= '0;
    end else if (w_accept) begin
      r_cycle_cnt <= '0;
    end else if (BUSY_out) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign CYCLE_CNT_out = r_cycle_cnt;
`else
  assign CYCLE_CNT_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_ctrl.sv
// ----------------------------------------------------------------
// tb_gemm_tile_ctrl : scoreboard bench for gemm_tile_ctrl.
// Rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_gemm_tile_ctrl;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          START = 1'b0;
  logic          STALL = 1'b0;
  logic [8:0]    M_SIZE_in = '0;
  logic [8:0]    K_SIZE_in = '0;
  logic [8:0]    N_SIZE_in = '0;
  logic          BUSY_out, IS_FINISHED_out;
  logic          OPND1_RD_EN, OPND2_RD_EN, ACC_CLR_out, OUT_WR_EN;
  logic [AW-1:0] OPND1_ADDR, OPND2_ADDR, OUT_ADDR;
  logic [31:0]   CYCLE_CNT_out;

  gemm_tile_ctrl #(
    .PE_ROWS(R), .PE_COLS(C),
    .MAX_M_SIZE_LOG2(9), .MAX_K_SIZE_LOG2(9), .MAX_N_SIZE_LOG2(9),
    .OPND_AWIDTH(AW), .OUT_AWIDTH(AW)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .STALL(STALL),
    .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in), .N_SIZE_in(N_SIZE_in),
    .BUSY_out(BUSY_out), .IS_FINISHED_out(IS_FINISHED_out),
    .OPND1_RD_EN(OPND1_RD_EN), .OPND1_ADDR(OPND1_ADDR),
    .OPND2_RD_EN(OPND2_RD_EN), .OPND2_ADDR(OPND2_ADDR),
    .ACC_CLR_out(ACC_CLR_out), .OUT_WR_EN(OUT_WR_EN), .OUT_ADDR(OUT_ADDR),
    .CYCLE_CNT_out(CYCLE_CNT_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          clr;
  } rd_t;

  rd_t           rd_q[$];
  logic [AW-1:0] wr_q[$];
  rd_t           m_exp, m_got;
  logic [AW-1:0] m_wexp;
  int checks = 0, errors = 0;
  int n_rd = 0, n_wr = 0, n_clr = 0, n_fin = 0;
  logic [67:0] all_out;

  assign all_out = {BUSY_out, IS_FINISHED_out, OPND1_RD_EN, OPND1_ADDR, OPND2_RD_EN,
                    OPND2_ADDR, ACC_CLR_out, OUT_WR_EN, OUT_ADDR, CYCLE_CNT_out};

  // Output monitor: every read/write is popped against the scoreboard
  always @(negedge CLK) begin
    if (RSTn) begin
      if (IS_FINISHED_out) n_fin++;
      if (ACC_CLR_out) n_clr++;
      if (STALL) begin
        checks++;
        if (OPND1_RD_EN || OPND2_RD_EN || OUT_WR_EN || ACC_CLR_out) begin
          errors++;
          $display("FAIL stall_enables: rd1=%b rd2=%b wr=%b clr=%b, required all 0",
                   OPND1_RD_EN, OPND2_RD_EN, OUT_WR_EN, ACC_CLR_out);
        end
      end
      if (OPND1_RD_EN || OPND2_RD_EN || ACC_CLR_out) begin
        checks++;
        n_rd++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: a1=%0d a2=%0d clr=%b, no read expected",
                   OPND1_ADDR, OPND2_ADDR, ACC_CLR_out);
        end else begin
          m_exp = rd_q.pop_front();
          m_got = '{a1: OPND1_ADDR, a2: OPND2_ADDR, clr: ACC_CLR_out};
          if (!(OPND1_RD_EN && OPND2_RD_EN) || m_got !== m_exp) begin
            errors++;
            $display("FAIL rd_seq: en=%b%b a1=%0d a2=%0d clr=%b, required en=11 a1=%0d a2=%0d clr=%b",
                     OPND1_RD_EN, OPND2_RD_EN, OPND1_ADDR, OPND2_ADDR, ACC_CLR_out,
                     m_exp.a1, m_exp.a2, m_exp.clr);
          end
        end
      end
      if (OUT_WR_EN) begin
        checks++;
        n_wr++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: addr=%0d, no write expected", OUT_ADDR);
        end else begin
          m_wexp = wr_q.pop_front();
          if (OUT_ADDR !== m_wexp) begin
            errors++;
            $display("FAIL wr_seq: addr=%0d, required %0d", OUT_ADDR, m_wexp);
          end
        end
      end
    end
  end

  task automatic push_model(input int m, input int k, input int n);
    int  mt_n, nt_n;
    rd_t e;
    if (m == 0 || k == 0 || n == 0) return;
    mt_n = (m + R - 1) / R;
    nt_n = (n + C - 1) / C;
    for (int mt = 0; mt < mt_n; mt++) begin
      for (int nt = 0; nt < nt_n; nt++) begin
        for (int kk = 0; kk < k; kk++) begin
          e.a1  = AW'(mt * k + kk);
          e.a2  = AW'(nt * k + kk);
          e.clr = (kk == 0);
          rd_q.push_back(e);
        end
        for (int r = 0; r < R; r++)
          if (mt * R + r < m) wr_q.push_back(AW'((mt * R + r) * nt_n + nt));
      end
    end
  endtask

  task automatic run_op(input int m, input int k, input int n, input int stall_at,
                        input int stall_len, input int restart_at, input string name);
    int          mt_n, nt_n, lat, cyc, exp_rd, exp_wr, exp_clr;
    bit          zero;
    logic [31:0] exp_cnt;
    zero    = (m == 0 || k == 0 || n == 0);
    mt_n    = (m + R - 1) / R;
    nt_n    = (n + C - 1) / C;
    lat     = (zero ? 1 : 1 + mt_n * nt_n * (k + 2 * R + C - 1)) + stall_len;
    exp_rd  = zero ? 0 : mt_n * nt_n * k;
    exp_wr  = zero ? 0 : m * nt_n;
    exp_clr = zero ? 0 : mt_n * nt_n;
`ifdef GEMM_TILE_CTRL_PERF_CNT_EN
    exp_cnt = 32'(lat);
`else
    exp_cnt = 32'd0;
`endif
    push_model(m, k, n);
    n_rd = 0; n_wr = 0; n_clr = 0; n_fin = 0;
    @(posedge CLK); #1;
    M_SIZE_in = 9'(m); K_SIZE_in = 9'(k); N_SIZE_in = 9'(n);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    M_SIZE_in = 9'($urandom_range(1, 511));
    K_SIZE_in = 9'($urandom_range(1, 511));
    N_SIZE_in = 9'($urandom_range(1, 511));
    cyc = 0;
    while (IS_FINISHED_out !== 1'b1 && cyc < lat + 100) begin
      if (cyc == stall_at) STALL = 1'b1;
      if (cyc == stall_at + stall_len) STALL = 1'b0;
      if (cyc == restart_at) START = 1'b1;
      if (cyc == restart_at + 1) START = 1'b0;
      @(posedge CLK); #1;
      cyc++;
    end
    STALL = 1'b0;
    START = 1'b0;
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency: %0d cycles, required %0d", name, cyc, lat);
    end
    checks++;
    if (CYCLE_CNT_out !== exp_cnt) begin
      errors++;
      $display("FAIL %s cycle_cnt: %0d, required %0d", name, CYCLE_CNT_out, exp_cnt);
    end
    checks++;
    if (BUSY_out !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_finish: %b, required 0", name, BUSY_out);
    end
    repeat (20) begin @(posedge CLK); #1; end
    checks++;
    if (n_fin != 1 || IS_FINISHED_out !== 1'b0) begin
      errors++;
      $display("FAIL %s finish_pulses: %0d (now %b), required 1 (now 0)", name, n_fin, IS_FINISHED_out);
    end
    checks++;
    if (n_rd != exp_rd || n_wr != exp_wr || n_clr != exp_clr || rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s counts: rd=%0d wr=%0d clr=%0d left=%0d/%0d, required rd=%0d wr=%0d clr=%0d left=0/0",
               name, n_rd, n_wr, n_clr, rd_q.size(), wr_q.size(), exp_rd, exp_wr, exp_clr);
    end
    checks++;
    if (CYCLE_CNT_out !== exp_cnt) begin
      errors++;
      $display("FAIL %s cycle_cnt_hold: %0d, required %0d", name, CYCLE_CNT_out, exp_cnt);
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (all_out !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: %h, required 0", all_out);
    end
    RSTn = 1'b1;
  endtask

  task automatic test_full();     run_op(16, 16, 16, -1, 0, -1, "full");       endtask
  task automatic test_ragged();   run_op(5, 3, 4, -1, 0, -1, "ragged");        endtask
  task automatic test_zero_k();   run_op(16, 0, 16, -1, 0, -1, "zero_k");      endtask
  task automatic test_stall();    run_op(16, 16, 16, 5, 10, -1, "stall_feed"); endtask
  task automatic test_stall_done(); run_op(5, 3, 4, 28, 3, -1, "stall_done"); endtask
  task automatic test_restart();  run_op(16, 16, 16, -1, 0, 3, "restart");     endtask

  task automatic test_reset_mid();
    push_model(16, 16, 16);
    @(posedge CLK); #1;
    M_SIZE_in = 9'd16; K_SIZE_in = 9'd16; N_SIZE_in = 9'd16;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (78) begin @(posedge CLK); #1; end
    checks++;
    if (OUT_WR_EN !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_in_write: wr_en=%b, required 1", OUT_WR_EN);
    end
    RSTn = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (all_out !== 68'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: %h, required 0", all_out);
    end
    RSTn = 1'b1;
    rd_q.delete();
    wr_q.delete();
    n_fin = 0;
    repeat (5) begin @(posedge CLK); #1; end
    checks++;
    if (n_fin != 0 || BUSY_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: pulses=%0d busy=%b, required 0 0", n_fin, BUSY_out);
    end
    run_op(16, 16, 16, -1, 0, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc;
    push_model(4, 2, 4);
    push_model(4, 2, 4);
    n_fin = 0;
    @(posedge CLK); #1;
    M_SIZE_in = 9'd4; K_SIZE_in = 9'd2; N_SIZE_in = 9'd4;
    START = 1'b1;
    @(posedge CLK); #1;
    cyc = 0;
    while (IS_FINISHED_out !== 1'b1 && cyc < 200) begin @(posedge CLK); #1; cyc++; end
    checks++;
    if (cyc != 14 || BUSY_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d busy=%b, required 14 0", cyc, BUSY_out);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if (BUSY_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: busy=%b, required 1", BUSY_out);
    end
    cyc = 0;
    while (IS_FINISHED_out !== 1'b1 && cyc < 200) begin @(posedge CLK); #1; cyc++; end
    checks++;
    if (cyc != 14) begin
      errors++;
      $display("FAIL b2b_second: latency=%0d, required 14", cyc);
    end
    repeat (20) begin @(posedge CLK); #1; end
    checks++;
    if (n_fin != 2 || rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_totals: pulses=%0d left=%0d/%0d, required 2 0/0", n_fin, rd_q.size(), wr_q.size());
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    test_reset();
    test_full();
    test_ragged();
    test_zero_k();
    test_stall();
    test_stall_done();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
